ir_rx_letter_queue: RTL and testbench

Receive-side counterpart of the transmit letter buffer. Takes 32-bit codes from the IR decoder (single-cycle new-code strobe) and checks that each is a legal 5-bit letter. Legal letters go into a circular queue. The queue feeds the enigma block one letter at a time for decryption, as paced single-cycle valid pulses. Sits between ir_decoder and the decrypting enigma instance; runs in the 100 MHz domain.

---
 rtl/ir_rx_letter_queue_pkg.sv | 22 ++
 rtl/ir_rx_letter_queue_if.sv | 29 ++
 rtl/ir_rx_letter_queue_mem.sv | 30 +++
 rtl/ir_rx_letter_queue.sv | 163 ++++++++++++++++
 tb/tb_ir_rx_letter_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ir_rx_letter_queue_pkg.sv
// Shared types and helpers for the IR receive letter queue.
package ir_rx_pkg;

  localparam int unsigned LETTER_W      = 5;
  localparam int unsigned ALPHABET_SIZE = 26;
  localparam int unsigned BAD_CNT_W     = 8;
  localparam int unsigned CODE_W        = 32;
  localparam int unsigned ERR_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EMIT = 2'd2,
    GAP  = 2'd3
  } rx_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BAD_CNT_W-1:0] sat_inc8(input logic [BAD_CNT_W-1:0] v);
    return (v == {BAD_CNT_W{1'b1}}) ? v : v + BAD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ir_rx_letter_queue_if.sv
// Decoder-side inputs and enigma-side outputs of the receive letter queue.
interface ir_rx_letter_queue_if #(
  parameter int unsigned DEPTH = 32
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                              new_code_in;
  logic [ir_rx_pkg::CODE_W-1:0]      code_in;
  logic [ir_rx_pkg::ERR_W-1:0]       error_in;
  logic                              hold_in;
  logic                              flush_in;
  logic                              data_valid_out;
  logic [ir_rx_pkg::LETTER_W-1:0]    data_out;
  logic [CNT_W-1:0]                  count_out;
  logic                              overflow_out;
  logic [ir_rx_pkg::BAD_CNT_W-1:0]   bad_code_count_out;

  modport master (
    output new_code_in, code_in, error_in, hold_in, flush_in,
    input  data_valid_out, data_out, count_out, overflow_out, bad_code_count_out
  );

  modport slave (
    input  new_code_in, code_in, error_in, hold_in, flush_in,
    output data_valid_out, data_out, count_out, overflow_out, bad_code_count_out
  );

endinterface

// File: rtl/ir_rx_letter_queue_mem.sv
// Simple dual-port letter RAM: synchronous write, one-cycle registered read.
module letter_queue_mem #(
  parameter int unsigned WIDTH = ir_rx_pkg::LETTER_W,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Array write and registered read port; no reset on storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ir_rx_letter_queue.sv
// Validates decoded IR codes, queues legal letters and paces them out to enigma.
module ir_rx_letter_queue
  import ir_rx_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned LETTER_MAX = ALPHABET_SIZE - 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  ir_rx_letter_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  rx_state_t               state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                    data_valid_q, data_valid_d;
  logic [LETTER_W-1:0]     data_out_q, data_out_d;
  logic                    overflow_q, overflow_d;
  logic [BAD_CNT_W-1:0]    bad_cnt_q, bad_cnt_d;

  logic                    code_legal;
  logic                    queue_full;
  logic                    wr_en;
  logic                    rd_en;
  logic                    bad_inc;
  logic [LETTER_W-1:0]     mem_rd_data;

  letter_queue_mem #(
    .WIDTH (LETTER_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk_in),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.code_in[LETTER_W-1:0]),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // Dequeue FSM: issue read, wait for RAM, emit one pulse, then enforce spacing.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    rd_en        = 1'b0;
    data_valid_d = 1'b0;
    data_out_d   = data_out_q;
    if (bus.flush_in) begin
      state_d   = IDLE;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((count_q != '0) && !bus.hold_in) begin
            rd_en   = 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          state_d = EMIT;
        end
        EMIT: begin
          data_valid_d = 1'b1;
          data_out_d   = mem_rd_data;
          gap_cnt_d    = '0;
          state_d      = GAP;
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Code acceptance, pointer/occupancy bookkeeping and error statistics.
  always_comb begin
    code_legal = (bus.code_in[CODE_W-1:LETTER_W] == '0) &&
                 (bus.code_in[LETTER_W-1:0] <= LETTER_W'(LETTER_MAX));
    queue_full = (count_q == CNT_W'(DEPTH));
    wr_en      = bus.new_code_in && code_legal && !queue_full && !bus.flush_in;
    bad_inc    = (bus.new_code_in && !code_legal) || (bus.error_in != '0);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bad_cnt_d  = bad_cnt_q;

    if (bus.flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A legal letter arriving on a full queue is lost even if a read issues now.
    if (bus.new_code_in && code_legal && queue_full) begin
      overflow_d = 1'b1;
    end
    // Illegal code and decoder error in the same cycle count once.
    if (bad_inc) begin
      bad_cnt_d = sat_inc8(bad_cnt_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      gap_cnt_q    <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      overflow_q   <= 1'b0;
      bad_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      gap_cnt_q    <= gap_cnt_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      overflow_q   <= overflow_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign bus.data_valid_out     = data_valid_q;
  assign bus.data_out           = data_out_q;
  assign bus.count_out          = count_q;
  assign bus.overflow_out       = overflow_q;
  assign bus.bad_code_count_out = bad_cnt_q;

endmodule

// File: tb/tb_ir_rx_letter_queue.sv
// Scoreboard bench for ir_rx_letter_queue: directed stimulus, decoupled pulse monitor.
module tb_ir_rx_letter_queue;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned GAP   = 16;
  localparam int SPACING = GAP + 3;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   pulses;
  int   max_cnt;
  logic [4:0] exp_q[$];
  int   pulse_cyc[$];

  ir_rx_letter_queue_if #(.DEPTH(DEPTH)) bus ();

  ir_rx_letter_queue #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .LETTER_MAX (25)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expected letter.
  always @(negedge clk) begin
    if (int'(bus.count_out) > max_cnt) max_cnt = int'(bus.count_out);
    if (bus.data_valid_out === 1'b1) begin
      logic [4:0] e;
      pulses++;
      pulse_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse data_out=%0d required=no_pulse", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          failures++;
          $display("FAIL pulse_data got=%0d required=%0d", bus.data_out, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [31:0] code, input logic [2:0] err,
                           input logic strobe, output int t_cyc);
    bus.new_code_in = strobe;
    bus.code_in     = code;
    bus.error_in    = err;
    @(posedge clk);
    #1;
    t_cyc = cyc;
    bus.new_code_in = 1'b0;
    bus.code_in     = '0;
    bus.error_in    = '0;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pulses < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (pulses < target) begin
      failures++;
      $display("FAIL %s pulses=%0d required=%0d", name, pulses, target);
    end
  endtask

  initial begin
    int t;
    int base;
    cyc = 0; checks = 0; failures = 0; pulses = 0; max_cnt = 0;
    rst_n = 1'b0;
    bus.new_code_in = 1'b0;
    bus.code_in     = '0;
    bus.error_in    = '0;
    bus.hold_in     = 1'b0;
    bus.flush_in    = 1'b0;

    // Reset values
    idle(3);
    check("rst_valid", 32'(bus.data_valid_out), 0);
    check("rst_data", 32'(bus.data_out), 0);
    check("rst_count", 32'(bus.count_out), 0);
    check("rst_overflow", 32'(bus.overflow_out), 0);
    check("rst_bad", 32'(bus.bad_code_count_out), 0);
    rst_n = 1'b1;
    idle(2);

    // Single letter latency
    exp_q.push_back(5'd7);
    send_code(32'h0000_0007, 3'd0, 1'b1, t);
    wait_pulses(1, 40, "single_pulse");
    check("latency", 32'(pulse_cyc[0] - t), 3);
    idle(30);
    check("single_count", 32'(bus.count_out), 0);

    // Back-to-back letters: order, spacing, peak occupancy
    max_cnt = 0;
    base = pulses;
    exp_q.push_back(5'd3); exp_q.push_back(5'd4); exp_q.push_back(5'd5);
    send_code(32'd3, 3'd0, 1'b1, t);
    send_code(32'd4, 3'd0, 1'b1, t);
    send_code(32'd5, 3'd0, 1'b1, t);
    wait_pulses(base + 3, 3 * SPACING + 30, "b2b_pulses");
    check("b2b_spacing1", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'(SPACING));
    check("b2b_spacing2", 32'(pulse_cyc[base + 2] - pulse_cyc[base + 1]), 32'(SPACING));
    check("b2b_peak_count", 32'(max_cnt), 2);
    idle(30);
    check("b2b_count", 32'(bus.count_out), 0);

    // Illegal codes and decoder errors
    base = pulses;
    send_code(32'h0000_001A, 3'd0, 1'b1, t);
    send_code(32'h0000_001F, 3'd0, 1'b1, t);
    send_code(32'h0000_0020, 3'd0, 1'b1, t);
    send_code(32'h0000_0000, 3'b010, 1'b0, t);
    idle(2);
    check("bad_count4", 32'(bus.bad_code_count_out), 4);
    check("bad_no_count", 32'(bus.count_out), 0);
    check("bad_no_overflow", 32'(bus.overflow_out), 0);
    send_code(32'h0000_0100, 3'b001, 1'b1, t);
    check("bad_combined_once", 32'(bus.bad_code_count_out), 5);
    idle(30);
    check("bad_no_pulse", 32'(pulses), 32'(base));
    for (int i = 0; i < 260; i++) send_code(32'd0, 3'b100, 1'b0, t);
    check("bad_saturate", 32'(bus.bad_code_count_out), 255);

    // Hold, fill past capacity, then drain
    bus.hold_in = 1'b1;
    base = pulses;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) exp_q.push_back(5'(i % 26));
      send_code(32'(i % 26), 3'd0, 1'b1, t);
    end
    idle(3);
    check("full_count", 32'(bus.count_out), 32);
    check("full_overflow", 32'(bus.overflow_out), 1);
    check("hold_no_pulse", 32'(pulses), 32'(base));
    bus.hold_in = 1'b0;
    wait_pulses(base + 32, 32 * SPACING + 40, "drain_pulses");
    idle(60);
    check("drain_exact", 32'(pulses), 32'(base + 32));
    check("drain_count", 32'(bus.count_out), 0);

    // Sustained traffic across pointer wrap
    base = pulses;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(5'(i % 26));
      send_code(32'(i % 26), 3'd0, 1'b1, t);
      idle(9);
    end
    wait_pulses(base + 40, 40 * SPACING + 60, "wrap_pulses");
    idle(30);
    check("wrap_count", 32'(bus.count_out), 0);

    // Flush while a read is in flight
    bus.hold_in = 1'b1;
    base = pulses;
    send_code(32'd9, 3'd0, 1'b1, t);
    send_code(32'd10, 3'd0, 1'b1, t);
    check("flush_pre_count", 32'(bus.count_out), 2);
    bus.hold_in = 1'b0;
    idle(1);
    check("flush_read_issued", 32'(bus.count_out), 1);
    bus.flush_in = 1'b1;
    idle(1);
    bus.flush_in = 1'b0;
    check("flush_count", 32'(bus.count_out), 0);
    idle(40);
    check("flush_no_pulse", 32'(pulses), 32'(base));
    check("flush_keeps_overflow", 32'(bus.overflow_out), 1);

    // Asynchronous reset during the gap
    base = pulses;
    exp_q.push_back(5'd12);
    send_code(32'd12, 3'd0, 1'b1, t);
    send_code(32'd13, 3'd0, 1'b1, t);
    wait_pulses(base + 1, 40, "gap_pulse");
    idle(3);
    check("gap_pre_count", 32'(bus.count_out), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.data_valid_out), 0);
    check("arst_data", 32'(bus.data_out), 0);
    check("arst_count", 32'(bus.count_out), 0);
    check("arst_overflow", 32'(bus.overflow_out), 0);
    check("arst_bad", 32'(bus.bad_code_count_out), 0);
    idle(2);
    rst_n = 1'b1;
    idle(60);
    check("arst_no_pulse", 32'(pulses), 32'(base + 1));
    check("arst_post_count", 32'(bus.count_out), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
